// File: rtl/memory_interface_pkg.sv
// Shared types and constants for the memory front end.
// Optional console port is enabled by defining MEMORY_INTERFACE_CONSOLE_EN.
package memory_interface_pkg;

    // Front-end control states
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StReadWait,
        StRespond,
        StConsole
    } state_e;

    // Request command encoding from the core
    localparam logic MEMORY_COMMAND_READ  = 1'b0;
    localparam logic MEMORY_COMMAND_WRITE = 1'b1;

    // Decoded destination of a request
    typedef enum logic [1:0] {
        TargetSram,
        TargetConsole,
        TargetFault
    } target_e;

endpackage

// File: rtl/memory_address_decoder.sv
// Combinational byte address -> target decode.
// Console decode exists only when MEMORY_INTERFACE_CONSOLE_EN is defined.
module memory_address_decoder
    import memory_interface_pkg::*;
#(
    parameter int unsigned MEMORY_WORDS    = 4096,
    parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000
) (
    input  logic [31:0] address,
    output target_e     target
);

    // One past the last SRAM byte; 33 bits so a full 4 GiB SRAM cannot wrap
    localparam logic [32:0] SramLimit = 33'(MEMORY_WORDS) << 2;

    // Priority decode: SRAM window, then console register, else fault
    always_comb begin
        target = TargetFault;
        if ({1'b0, address} < SramLimit) begin
            target = TargetSram;
        end
`ifdef MEMORY_INTERFACE_CONSOLE_EN
        else if (address[31:2] == CONSOLE_ADDRESS[31:2]) begin
            target = TargetConsole;
        end
`endif
    end

endmodule

// File: rtl/memory_interface.sv
// Single-request memory front end: core handshake -> synchronous SRAM with
// configurable read latency, sticky out-of-range fault, optional console byte
// port (enabled by defining MEMORY_INTERFACE_CONSOLE_EN).
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int unsigned MEMORY_WORDS    = 4096,
    parameter int unsigned READ_LATENCY    = 1,
    parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
    localparam int unsigned AW             = $clog2(MEMORY_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    // Core side
    input  logic          memory_enable,
    input  logic          memory_command,
    input  logic [31:0]   read_memory_address,
    input  logic [31:0]   write_memory_address,
    input  logic [31:0]   write_memory_data,
    input  logic [31:0]   write_memory_mask,
    output logic          memory_ready,
    output logic          memory_valid,
    output logic [31:0]   read_memory_data,
    // SRAM side
    output logic          sram_enable,
    output logic          sram_write_enable,
    output logic [AW-1:0] sram_address,
    output logic [31:0]   sram_write_data,
    output logic [31:0]   sram_write_mask,
    input  logic [31:0]   sram_read_data,
    // Console side
    output logic          console_valid,
    output logic [7:0]    console_data,
    input  logic          console_ready,
    // Status
    output logic          access_fault
);

    localparam logic [2:0] LatencyInit = 3'(READ_LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  counter_q, counter_d;
    logic [31:0] read_data_q, read_data_d;
    logic        fault_q, fault_d;

    logic        command_q;
    logic [31:0] address_q;
    logic [31:0] data_q;
    logic [31:0] mask_q;

    target_e     target;
    logic        accept;

    assign accept = memory_enable && memory_ready;

    memory_address_decoder #(
        .MEMORY_WORDS   (MEMORY_WORDS),
        .CONSOLE_ADDRESS(CONSOLE_ADDRESS)
    ) u_decoder (
        .address(address_q),
        .target (target)
    );

    // Request capture on acceptance; address picked by command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            command_q <= MEMORY_COMMAND_READ;
            address_q <= '0;
            data_q    <= '0;
            mask_q    <= '0;
        end else if (accept) begin
            command_q <= memory_command;
            address_q <= (memory_command == MEMORY_COMMAND_WRITE) ? write_memory_address
                                                                  : read_memory_address;
            data_q    <= write_memory_data;
            mask_q    <= write_memory_mask;
        end
    end

    // Control state, latency counter, response data and sticky fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        read_data_d = read_data_q;
        fault_d     = fault_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (target == TargetSram) begin
                    if (command_q == MEMORY_COMMAND_WRITE) begin
                        state_d = StIdle;
                    end else begin
                        counter_d = LatencyInit;
                        state_d   = StReadWait;
                    end
                end
`ifdef MEMORY_INTERFACE_CONSOLE_EN
                else if (target == TargetConsole) begin
                    if (command_q == MEMORY_COMMAND_WRITE) begin
                        state_d = StConsole;
                    end else begin
                        // Console status read reports whether a byte would be taken now
                        read_data_d = {31'b0, console_ready};
                        state_d     = StRespond;
                    end
                end
`endif
                else begin
                    fault_d = 1'b1;
                    if (command_q == MEMORY_COMMAND_WRITE) begin
                        state_d = StIdle;
                    end else begin
                        read_data_d = '0;
                        state_d     = StRespond;
                    end
                end
            end
            StReadWait: begin
                // Counter == 1 marks the cycle the SRAM presents the word
                if (counter_q <= 3'd1) begin
                    read_data_d = sram_read_data;
                    state_d     = StRespond;
                end else begin
                    counter_d = counter_q - 3'd1;
                end
            end
            StRespond: begin
                state_d = accept ? StIssue : StIdle;
            end
            StConsole: begin
`ifdef MEMORY_INTERFACE_CONSOLE_EN
                if (console_ready) begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; ready is gated by reset so nothing is taken while held
    always_comb begin
        memory_ready      = reset && ((state_q == StIdle) || (state_q == StRespond));
        memory_valid      = (state_q == StRespond);
        sram_enable       = (state_q == StIssue) && (target == TargetSram);
        sram_write_enable = sram_enable && (command_q == MEMORY_COMMAND_WRITE);
    end

    assign read_memory_data = read_data_q;
    assign sram_address     = address_q[AW+1:2];
    assign sram_write_data  = data_q;
    assign sram_write_mask  = mask_q;
    assign access_fault     = fault_q;

`ifdef MEMORY_INTERFACE_CONSOLE_EN
    assign console_valid = (state_q == StConsole);
    assign console_data  = console_valid ? data_q[7:0] : 8'h00;
`else
    logic unused_console_ready;
    assign unused_console_ready = console_ready;
    assign console_valid        = 1'b0;
    assign console_data         = 8'h00;
`endif

endmodule

// File: tb/tb_memory_interface.sv
// Directed self-checking bench for memory_interface: one instance with read
// latency 1 for the main tests, a second with latency 3 for read throughput.
module tb_memory_interface;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance (READ_LATENCY = 1)
    logic        memory_enable, memory_command;
    logic [31:0] read_memory_address, write_memory_address;
    logic [31:0] write_memory_data, write_memory_mask;
    logic        memory_ready, memory_valid;
    logic [31:0] read_memory_data;
    logic        sram_enable, sram_write_enable;
    logic [11:0] sram_address;
    logic [31:0] sram_write_data, sram_write_mask, sram_read_data;
    logic        console_valid, console_ready;
    logic [7:0]  console_data;
    logic        access_fault;

    // Second instance (READ_LATENCY = 3), read-only traffic
    logic        en3, ready3, valid3;
    logic [31:0] raddr3, rdata3;
    logic        sen3, swe3;
    logic [11:0] saddr3;
    logic [31:0] swdata3, swmask3, srdata3;
    logic        cvalid3, fault3;
    logic [7:0]  cdata3;

    memory_interface #(
        .MEMORY_WORDS(4096),
        .READ_LATENCY(1)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .memory_enable       (memory_enable),
        .memory_command      (memory_command),
        .read_memory_address (read_memory_address),
        .write_memory_address(write_memory_address),
        .write_memory_data   (write_memory_data),
        .write_memory_mask   (write_memory_mask),
        .memory_ready        (memory_ready),
        .memory_valid        (memory_valid),
        .read_memory_data    (read_memory_data),
        .sram_enable         (sram_enable),
        .sram_write_enable   (sram_write_enable),
        .sram_address        (sram_address),
        .sram_write_data     (sram_write_data),
        .sram_write_mask     (sram_write_mask),
        .sram_read_data      (sram_read_data),
        .console_valid       (console_valid),
        .console_data        (console_data),
        .console_ready       (console_ready),
        .access_fault        (access_fault)
    );

    memory_interface #(
        .MEMORY_WORDS(4096),
        .READ_LATENCY(3)
    ) u_dut_lat3 (
        .clk                 (clk),
        .reset               (reset),
        .memory_enable       (en3),
        .memory_command      (1'b0),
        .read_memory_address (raddr3),
        .write_memory_address(32'h0),
        .write_memory_data   (32'h0),
        .write_memory_mask   (32'h0),
        .memory_ready        (ready3),
        .memory_valid        (valid3),
        .read_memory_data    (rdata3),
        .sram_enable         (sen3),
        .sram_write_enable   (swe3),
        .sram_address        (saddr3),
        .sram_write_data     (swdata3),
        .sram_write_mask     (swmask3),
        .sram_read_data      (srdata3),
        .console_valid       (cvalid3),
        .console_data        (cdata3),
        .console_ready       (1'b0),
        .access_fault        (fault3)
    );

    // SRAM models: word array plus output pipeline of the instance's latency
    logic [31:0] mem0 [4096];
    logic [31:0] mem1 [4096];
    logic [31:0] pipe0;
    logic [31:0] pipe1a, pipe1b, pipe1c;

    always @(posedge clk) begin
        if (sram_enable) begin
            if (sram_write_enable) begin
                mem0[sram_address] <= (mem0[sram_address] & ~sram_write_mask) |
                                      (sram_write_data & sram_write_mask);
            end else begin
                pipe0 <= mem0[sram_address];
            end
        end
    end
    assign sram_read_data = pipe0;

    always @(posedge clk) begin
        if (sen3 && !swe3) begin
            pipe1a <= mem1[saddr3];
        end
        pipe1b <= pipe1a;
        pipe1c <= pipe1b;
    end
    assign srdata3 = pipe1c;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!memory_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check_eq("ready_timeout", 32'(memory_ready), 32'd1);
    endtask

    // Issue a read; lat counts cycles from acceptance (1 = ISSUE cycle) to valid
    task automatic do_read(input logic [31:0] addr, output int lat, output logic [31:0] data,
                           output logic [31:0] issue_addr);
        wait_ready();
        memory_enable       = 1'b1;
        memory_command      = 1'b0;
        read_memory_address = addr;
        tick();
        memory_enable = 1'b0;
        lat           = 1;
        issue_addr    = 32'(sram_address);
        while (!memory_valid && lat < 20) begin
            tick();
            lat++;
        end
        data = read_memory_data;
    endtask

    // Issue a write; returns the SRAM strobes seen in the ISSUE cycle
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] mask, output logic [1:0] strobes);
        wait_ready();
        memory_enable        = 1'b1;
        memory_command       = 1'b1;
        write_memory_address = addr;
        write_memory_data    = data;
        write_memory_mask    = mask;
        tick();
        memory_enable = 1'b0;
        strobes       = {sram_enable, sram_write_enable};
    endtask

    int          lat;
    logic [31:0] rd, ia;
    logic [1:0]  st;
    int          accepts, nval, a1, v1, v2, vcount;
    logic        pending;
    logic [31:0] d1, d2;

    initial begin
        mem0[4]    <= 32'hDEADBEEF;
        mem0[8]    <= 32'hAAAAAAAA;
        mem0[4095] <= 32'hCAFEF00D;
        mem1[4]    <= 32'h11111111;
        mem1[8]    <= 32'h22222222;

        reset                = 1'b0;
        memory_enable        = 1'b0;
        memory_command       = 1'b0;
        read_memory_address  = '0;
        write_memory_address = '0;
        write_memory_data    = '0;
        write_memory_mask    = '0;
        console_ready        = 1'b0;
        en3                  = 1'b0;
        raddr3               = '0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ready", 32'(memory_ready), 32'd0);
        check_eq("rst_valid", 32'(memory_valid), 32'd0);
        check_eq("rst_sram_en", 32'({sram_enable, sram_write_enable}), 32'd0);
        check_eq("rst_rdata", read_memory_data, 32'd0);
        check_eq("rst_fault", 32'(access_fault), 32'd0);
        check_eq("rst_sram_addr", 32'(sram_address), 32'd0);
        check_eq("rst_console", 32'({console_valid, console_data}), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("ready_after_rst", 32'(memory_ready), 32'd1);

        // Preloaded read at 0x10
        do_read(32'h10, lat, rd, ia);
        check_eq("rd10_latency", 32'(lat), 32'd3);
        check_eq("rd10_data", rd, 32'hDEADBEEF);
        check_eq("rd10_sram_addr", ia, 32'd4);
        check_eq("rd10_ready_in_respond", 32'(memory_ready), 32'd1);
        tick();
        check_eq("rd10_valid_pulse", 32'(memory_valid), 32'd0);
        check_eq("rd10_rdata_held", read_memory_data, 32'hDEADBEEF);
        check_eq("no_fault_yet", 32'(access_fault), 32'd0);

        // Masked write then read back
        do_write(32'h20, 32'h12345678, 32'h0000FFFF, st);
        check_eq("wr20_strobes", 32'(st), 32'd3);
        check_eq("wr20_sram_wdata", sram_write_data, 32'h12345678);
        tick();
        check_eq("wr20_ready_a2", 32'(memory_ready), 32'd1);
        do_read(32'h20, lat, rd, ia);
        check_eq("rd20_data", rd, 32'hAAAA5678);

        // Top SRAM word, then first out-of-range word
        do_read(32'h3FFC, lat, rd, ia);
        check_eq("rd_top_latency", 32'(lat), 32'd3);
        check_eq("rd_top_data", rd, 32'hCAFEF00D);
        check_eq("top_no_fault", 32'(access_fault), 32'd0);
        do_read(32'h4000, lat, rd, ia);
        check_eq("rd_4000_latency", 32'(lat), 32'd2);
        check_eq("rd_4000_fault", 32'(access_fault), 32'd1);

        // Far out-of-range read, then a good read with fault still sticky
        do_read(32'h0001_0000, lat, rd, ia);
        check_eq("rd_oor_latency", 32'(lat), 32'd2);
        check_eq("rd_oor_data", rd, 32'd0);
        check_eq("rd_oor_fault", 32'(access_fault), 32'd1);
        do_read(32'h10, lat, rd, ia);
        check_eq("rd_after_fault_data", rd, 32'hDEADBEEF);
        check_eq("rd_after_fault_lat", 32'(lat), 32'd3);
        check_eq("fault_sticky", 32'(access_fault), 32'd1);

`ifdef MEMORY_INTERFACE_CONSOLE_EN
        // Console write stalls until console_ready
        do_write(32'h1000_0000, 32'h00000041, 32'h0, st);
        check_eq("con_no_sram", 32'(st), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("con_valid_held", 32'(console_valid), 32'd1);
            check_eq("con_data", 32'(console_data), 32'h41);
            check_eq("con_not_ready", 32'(memory_ready), 32'd0);
            tick();
        end
        console_ready = 1'b1;
        check_eq("con_valid_at_ready", 32'(console_valid), 32'd1);
        tick();
        console_ready = 1'b0;
        check_eq("con_valid_drop", 32'(console_valid), 32'd0);
        check_eq("con_ready_after", 32'(memory_ready), 32'd1);
        console_ready = 1'b1;
        do_read(32'h1000_0000, lat, rd, ia);
        console_ready = 1'b0;
        check_eq("con_read_latency", 32'(lat), 32'd2);
        check_eq("con_read_data", rd, 32'd1);
`else
        // Without the console, its address is just another fault
        do_write(32'h1000_0000, 32'h00000041, 32'h0, st);
        check_eq("con_off_no_sram", 32'(st), 32'd0);
        tick();
        check_eq("con_off_ready", 32'(memory_ready), 32'd1);
        check_eq("con_off_port", 32'({console_valid, console_data}), 32'd0);
        console_ready = 1'b1;
        do_read(32'h1000_0000, lat, rd, ia);
        console_ready = 1'b0;
        check_eq("con_off_read_latency", 32'(lat), 32'd2);
        check_eq("con_off_read_data", rd, 32'd0);
`endif

        // Latency 3: second read held on the bus is taken in RESPOND
        en3     = 1'b1;
        raddr3  = 32'h10;
        accepts = 0;
        nval    = 0;
        a1      = -100;
        v1      = -100;
        v2      = -100;
        d1      = '0;
        d2      = '0;
        for (int t = 0; t < 30; t++) begin
            if (valid3) begin
                nval++;
                if (nval == 1) begin
                    v1 = t;
                    d1 = rdata3;
                end else begin
                    v2 = t;
                    d2 = rdata3;
                end
            end
            pending = en3 && ready3;
            tick();
            if (pending) begin
                accepts++;
                if (accepts == 1) begin
                    a1     = t;
                    raddr3 = 32'h20;
                end else begin
                    en3 = 1'b0;
                end
            end
        end
        check_eq("lat3_first_valid", 32'(v1 - a1), 32'd5);
        check_eq("lat3_spacing", 32'(v2 - v1), 32'd5);
        check_eq("lat3_valid_count", 32'(nval), 32'd2);
        check_eq("lat3_data1", d1, 32'h11111111);
        check_eq("lat3_data2", d2, 32'h22222222);

        // Reset during READ_WAIT drops the request
        wait_ready();
        memory_enable       = 1'b1;
        memory_command      = 1'b0;
        read_memory_address = 32'h20;
        tick();
        memory_enable = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(memory_ready), 32'd0);
        check_eq("midrst_valid", 32'(memory_valid), 32'd0);
        check_eq("midrst_sram_en", 32'(sram_enable), 32'd0);
        check_eq("midrst_rdata", read_memory_data, 32'd0);
        check_eq("midrst_fault", 32'(access_fault), 32'd0);
        tick();
        tick();
        reset  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (memory_valid) vcount++;
            tick();
        end
        check_eq("midrst_no_valid", 32'(vcount), 32'd0);
        do_read(32'h20, lat, rd, ia);
        check_eq("postrst_data", rd, 32'hAAAA5678);
        check_eq("postrst_latency", 32'(lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
